regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with an integrated scoreboard, the successor to the single-write, dual-read CPU register file. It provides `NRD` asynchronous read ports and two synchronous write ports, with same-cycle write-to-read forwarding. A per-register pending bit is set on destination allocation and cleared on writeback, so the issue stage can stall on read-after-write hazards. It sits between decode/issue (reads, allocation) and the two writeback paths of a dual-issue datapath.

## Interface
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers; power of two, ≥ 4
- `NRD`, 2, number of read ports, 1..4
- `ZERO_REG`, 1, when 1, register 0 is hardwired to zero
- `AW` (localparam), `$clog2(NREGS)`, address width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `we0`, `we1`  in  1 each  write enables for write ports 0 and 1
- `waddr0`, `waddr1`  in  AW each  write addresses
- `wdata0`, `wdata1`  in  XLEN each  write data
- `alloc_valid`  in  1  mark `alloc_addr` pending this cycle
- `alloc_addr`  in  AW  destination being allocated
- `raddr`  in  NRD*AW  packed read addresses; port i is at `[i*AW +: AW]`
- `rdata`  out  NRD*XLEN  packed read data; combinational
- `rbusy`  out  NRD  per read port, the pending bit of the addressed register after forwarding; combinational
- `pend_cnt`  out  AW+1  registered count of pending registers

## Operation
- **Storage.** `NREGS` x `XLEN` array and `NREGS` pending bits.
- **Writes.** Each enabled port updates its register at the clock edge.
  - If both ports are enabled with the same address, port 1 wins.
- **Zero register.** With `ZERO_REG=1`, register 0 ignores writes and allocations, always reads 0, and its pending bit is always 0. With `ZERO_REG=0`, register 0 behaves like every other register.
- **Read data, per port, in priority order:**
  1. `ZERO_REG=1` and address 0 → 0.
  2. `we1` and `waddr1` match → `wdata1`.
  3. `we0` and `waddr0` match → `wdata0`.
  4. Otherwise → array contents.
- **`rbusy`, per port.** Equals the stored pending bit, forced to 0 if an enabled write port matches the address this cycle. Same-cycle allocation does not affect `rbusy`.
- **Next pending bit, per register:**
  - set if `alloc_valid` targets it;
  - else cleared if either write port targets it;
  - else held.
  - Allocation wins over writeback to the same register in the same cycle, because it represents a newer producer.
- **Allocating an already-pending register** is legal; the bit stays 1 and `pend_cnt` does not change.
- **Writing a non-pending register** is legal; the data is stored and the pending bit stays 0.
- **`pend_cnt`.** Updated every cycle to the population count of the next pending vector. Its range is 0..`NREGS`, which is why it is `AW+1` bits wide.

## Timing
- Reset (`rst`=1 at an edge) clears every register to 0, every pending bit to 0, and `pend_cnt` to 0.
- Reset takes priority over writes and allocations presented in the same cycle.
- Outputs during and after reset:
  - the cycle after reset, every `rdata` lane reads 0 (unless forwarded) and every `rbusy` is 0;
  - while `rst` is asserted, `rdata` and `rbusy` still forward combinationally;
  - state does not change until `rst` is released.
- Write latency:
  - forwarded to `rdata` in the same cycle;
  - visible from the array from the next cycle.
- Allocation latency: visible on `rbusy` and `pend_cnt` one cycle after `alloc_valid`.
- No handshake exists; every request is accepted unconditionally.

## Structure
- `regfile_pkg`:
  - default `XLEN` and `NREGS`;
  - a helper function that extracts field i from a packed vector;
  - the `popcount` function used for `pend_cnt`.
- Sub-module `regfile_scoreboard` holds the pending bits, the next-state logic, `pend_cnt`, and the per-port `rbusy` lookup.
- The data array, write-port priority and forwarding mux stay in `regfile_sb`.

## Test plan
- **Reset.** After `rst`, read all addresses on every port → `rdata`=0, `rbusy`=0, `pend_cnt`=0.
- **Write collision.** Same cycle: `we0` writes x5=0x1111_1111 and `we1` writes x5=0x2222_2222 → same-cycle read of x5 returns 0x2222_2222; next-cycle read also returns 0x2222_2222.
- **Forwarding.** Read x7 in the same cycle that `we0` writes x7=0xDEAD_BEEF → `rdata`=0xDEAD_BEEF; the array previously held 0.
- **Scoreboard.**
  - Allocate x3 → next cycle `rbusy`=1 and `pend_cnt`=1.
  - Write x3 with a same-cycle read → `rbusy`=0 and data forwarded; next cycle `pend_cnt`=0.
- **Allocate vs. write.** Allocate x9 while `we1` writes x9 in the same cycle → x9 data updated, pending=1, `pend_cnt` incremented.
- **Register 0.**
  - With `ZERO_REG=1`: write x0=0xFFFF_FFFF and allocate x0 → reads 0, `rbusy`=0, `pend_cnt` unchanged.
  - With `ZERO_REG=0`: the same stimulus reads back 0xFFFF_FFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Helpers take fixed-width operands; callers cast their vectors in and results out.
package regfile_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;

  localparam int FIELD_VEC_W = 256;
  localparam int FIELD_W     = 64;

  // popcount covers register files of up to POP_VEC_W entries
  localparam int POP_VEC_W = 256;
  localparam int POP_W     = 9;

  function automatic logic [FIELD_W-1:0] extractField(
    input logic [FIELD_VEC_W-1:0] vec,
    input int                     idx,
    input int                     width
  );
    logic [FIELD_VEC_W-1:0] shifted;
    logic [FIELD_W-1:0]     mask;
    shifted = vec >> (idx * width);
    mask    = (FIELD_W'(1) << width) - FIELD_W'(1);
    return shifted[FIELD_W-1:0] & mask;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [POP_VEC_W-1:0] vec);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_VEC_W; i++) begin
      cnt = cnt + POP_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: tracks registers awaiting writeback and reports
// per-read-port busy status for hazard stalls.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we0,
  input  logic [AW-1:0]     i_waddr0,
  input  logic              i_we1,
  input  logic [AW-1:0]     i_waddr1,
  input  logic              i_allocValid,
  input  logic [AW-1:0]     i_allocAddr,
  input  logic [NRD*AW-1:0] i_raddr,
  output logic [NRD-1:0]    o_rbusy,
  output logic [AW:0]       o_pendCnt
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pendNext;
  logic [AW:0]      r_pendCnt;

  // Allocation beats writeback: it names a newer producer of the same register.
  always_comb begin
    w_pendNext = r_pend;
    for (int r = 0; r < NREGS; r++) begin
      if (i_allocValid && (i_allocAddr == AW'(r))) begin
        w_pendNext[r] = 1'b1;
      end else if ((i_we0 && (i_waddr0 == AW'(r))) || (i_we1 && (i_waddr1 == AW'(r)))) begin
        w_pendNext[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_pendNext[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= '0;
      r_pendCnt <= '0;
    end else begin
      r_pend    <= w_pendNext;
      r_pendCnt <= (AW+1)'(popcount(POP_VEC_W'(w_pendNext)));
    end
  end

  assign o_pendCnt = r_pendCnt;

  // A write landing this cycle satisfies the reader, so it is no longer busy.
  for (genvar gp = 0; gp < NRD; gp++) begin : g_busy
    logic [AW-1:0] w_rAddr;
    logic          w_wrHit;
    assign w_rAddr     = AW'(extractField(FIELD_VEC_W'(i_raddr), gp, AW));
    assign w_wrHit     = (i_we0 && (i_waddr0 == w_rAddr)) || (i_we1 && (i_waddr1 == w_rAddr));
    assign o_rbusy[gp] = r_pend[w_rAddr] & ~w_wrHit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports, same-cycle forwarding and
// an integrated pending-bit scoreboard for RAW hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr0,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata0,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wrEn0;
  logic            w_wrEn1;

  assign w_wrEn0 = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_wrEn1 = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Port 1 is written last so it wins an address collision with port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      if (w_wrEn0) begin
        r_mem[waddr0] <= wdata0;
      end
      if (w_wrEn1) begin
        r_mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar gp = 0; gp < NRD; gp++) begin : g_read
    logic [AW-1:0]   w_rAddr;
    logic [XLEN-1:0] w_rData;

    assign w_rAddr = AW'(extractField(FIELD_VEC_W'(raddr), gp, AW));

    always_comb begin
      if ((ZERO_REG != 0) && (w_rAddr == '0)) begin
        w_rData = '0;
      end else if (we1 && (waddr1 == w_rAddr)) begin
        w_rData = wdata1;
      end else if (we0 && (waddr0 == w_rAddr)) begin
        w_rData = wdata0;
      end else begin
        w_rData = r_mem[w_rAddr];
      end
    end

    assign rdata[gp*XLEN +: XLEN] = w_rData;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_we0        (we0),
    .i_waddr0     (waddr0),
    .i_we1        (we1),
    .i_waddr1     (waddr1),
    .i_allocValid (alloc_valid),
    .i_allocAddr  (alloc_addr),
    .i_raddr      (raddr),
    .o_rbusy      (rbusy),
    .o_pendCnt    (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with a hardwired zero register
// and one without, both driven by the same stimulus.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        allocValid;
  logic [4:0]  allocAddr;
  logic [9:0]  raddr;
  logic [63:0] rdataZ, rdataN;
  logic [1:0]  rbusyZ, rbusyN;
  logic [5:0]  pendCntZ, pendCntN;

  int checkCount = 0;
  int passCount  = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .alloc_valid(allocValid), .alloc_addr(allocAddr),
    .raddr(raddr), .rdata(rdataZ), .rbusy(rbusyZ), .pend_cnt(pendCntZ)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(0)) dutNz (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .alloc_valid(allocValid), .alloc_addr(allocAddr),
    .raddr(raddr), .rdata(rdataN), .rbusy(rbusyN), .pend_cnt(pendCntN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drive all inputs, then let combinational outputs settle before checking.
  task automatic applyStimulus(
    input logic e0, input logic [4:0] a0, input logic [31:0] d0,
    input logic e1, input logic [4:0] a1, input logic [31:0] d1,
    input logic al, input logic [4:0] aa,
    input logic [4:0] r0, input logic [4:0] r1
  );
    we0 = e0; waddr0 = a0; wdata0 = d0;
    we1 = e1; waddr1 = a1; wdata1 = d1;
    allocValid = al; allocAddr = aa;
    raddr = {r1, r0};
    #1;
  endtask

  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tickClock();
    tickClock();
    rst = 1'b0;

    // Reset state across every address on both ports
    for (int a = 0; a < 32; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      checkOutput("reset_rdata_z", rdataZ, 64'h0);
      checkOutput("reset_rdata_n", rdataN, 64'h0);
      checkOutput("reset_rbusy_z", {62'h0, rbusyZ}, 64'h0);
      checkOutput("reset_rbusy_n", {62'h0, rbusyN}, 64'h0);
    end
    checkOutput("reset_pendcnt_z", {58'h0, pendCntZ}, 64'h0);
    checkOutput("reset_pendcnt_n", {58'h0, pendCntN}, 64'h0);

    // Write collision on x5: port 1 wins
    applyStimulus(1, 5, 32'h1111_1111, 1, 5, 32'h2222_2222, 0, 0, 5, 0);
    checkOutput("collide_fwd", {32'h0, rdataZ[31:0]}, 64'h2222_2222);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("collide_array", {32'h0, rdataZ[31:0]}, 64'h2222_2222);
    checkOutput("collide_array_n", {32'h0, rdataN[31:0]}, 64'h2222_2222);

    // Forwarding on port 1
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("fwd_before", {32'h0, rdataZ[63:32]}, 64'h0);
    applyStimulus(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("fwd_same_cycle", {32'h0, rdataZ[63:32]}, 64'hDEAD_BEEF);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("fwd_array", {32'h0, rdataZ[63:32]}, 64'hDEAD_BEEF);

    // Scoreboard: allocate x3, then write it back
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    checkOutput("alloc_same_cycle_busy", {63'h0, rbusyZ[0]}, 64'h0);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("alloc_busy", {63'h0, rbusyZ[0]}, 64'h1);
    checkOutput("alloc_pendcnt", {58'h0, pendCntZ}, 64'h1);
    applyStimulus(0, 0, 0, 1, 3, 32'h3333_0003, 0, 0, 3, 0);
    checkOutput("wb_busy_fwd", {63'h0, rbusyZ[0]}, 64'h0);
    checkOutput("wb_data_fwd", {32'h0, rdataZ[31:0]}, 64'h3333_0003);
    checkOutput("wb_pendcnt_held", {58'h0, pendCntZ}, 64'h1);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("wb_pendcnt", {58'h0, pendCntZ}, 64'h0);
    checkOutput("wb_busy", {63'h0, rbusyZ[0]}, 64'h0);
    checkOutput("wb_data", {32'h0, rdataZ[31:0]}, 64'h3333_0003);

    // Allocate and write x9 in the same cycle: allocation wins
    applyStimulus(0, 0, 0, 1, 9, 32'h9999_0000, 1, 9, 0, 9);
    checkOutput("allocwr_busy_now", {63'h0, rbusyZ[1]}, 64'h0);
    checkOutput("allocwr_data_now", {32'h0, rdataZ[63:32]}, 64'h9999_0000);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    checkOutput("allocwr_busy", {63'h0, rbusyZ[1]}, 64'h1);
    checkOutput("allocwr_pendcnt", {58'h0, pendCntZ}, 64'h1);
    checkOutput("allocwr_data", {32'h0, rdataZ[63:32]}, 64'h9999_0000);

    // Re-allocate pending x9 and write non-pending x10: count unchanged
    applyStimulus(1, 10, 32'h0000_00AA, 0, 0, 0, 1, 9, 10, 9);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 10, 9);
    checkOutput("realloc_pendcnt", {58'h0, pendCntZ}, 64'h1);
    checkOutput("nonpend_busy", {62'h0, rbusyZ}, 64'h2);
    checkOutput("nonpend_data", {32'h0, rdataZ[31:0]}, 64'h0000_00AA);

    // Register 0: write all-ones and allocate it
    applyStimulus(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("x0_fwd_z", {32'h0, rdataZ[31:0]}, 64'h0);
    checkOutput("x0_fwd_n", {32'h0, rdataN[31:0]}, 64'hFFFF_FFFF);
    checkOutput("x0_busy_now_n", {63'h0, rbusyN[0]}, 64'h0);
    tickClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_data_z", {32'h0, rdataZ[31:0]}, 64'h0);
    checkOutput("x0_busy_z", {63'h0, rbusyZ[0]}, 64'h0);
    checkOutput("x0_pendcnt_z", {58'h0, pendCntZ}, 64'h1);
    checkOutput("x0_data_n", {32'h0, rdataN[31:0]}, 64'hFFFF_FFFF);
    checkOutput("x0_busy_n", {63'h0, rbusyN[0]}, 64'h1);
    checkOutput("x0_pendcnt_n", {58'h0, pendCntN}, 64'h2);

    // Reset beats a same-cycle write/alloc, but forwarding still works during it
    rst = 1'b1;
    applyStimulus(1, 12, 32'h0000_ABCD, 0, 0, 0, 1, 12, 12, 5);
    checkOutput("rst_fwd", {32'h0, rdataZ[31:0]}, 64'h0000_ABCD);
    checkOutput("rst_busy", {62'h0, rbusyZ}, 64'h0);
    tickClock();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 5);
    checkOutput("rst_cleared_data", rdataZ, 64'h0);
    checkOutput("rst_cleared_busy", {62'h0, rbusyZ}, 64'h0);
    checkOutput("rst_pendcnt_z", {58'h0, pendCntZ}, 64'h0);
    checkOutput("rst_pendcnt_n", {58'h0, pendCntN}, 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    checkOutput("rst_x0_n", rdataN, 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
